spi_frame_slave: RTL and testbench
==================================

# spi_frame_slave

Parametrised SPI slave for the LED-control path on the Zybo Z7-20 fabric. Receives a command/address/payload frame on the external SPI bus in any of the four SPI modes. Presents completed write frames as a one-cycle pulse in the `sysclk` domain. Serves read commands by fetching a payload from the LED register file and shifting it out on MISO within the same frame.

## Interface
- `CMD_BITS`, 8, command field width
- `ADDR_BITS`, 8, address field width
- `PAYLOAD_BITS`, 8, payload field width
- `CPOL`, 0, SCLK idle level
- `CPHA`, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- `SYNC_STAGES`, 2, synchroniser depth for `sclk`, `cs_n` and `mosi` (≥2)
- `sysclk` in 1: system clock, 125 MHz; sole clock of the block
- `rst_n` in 1: asynchronous, active-low reset
- `sclk` in 1: SPI clock from master, asynchronous to `sysclk`
- `cs_n` in 1: chip select, active-low
- `mosi` in 1: serial data in, MSB first
- `miso` out 1: serial data out, MSB first
- `miso_oe` out 1: MISO output enable, high while synchronised `cs_n` is low
- `o_cmd` out `CMD_BITS`: command of last completed write frame
- `o_addr` out `ADDR_BITS`: address of last completed write frame
- `o_payload` out `PAYLOAD_BITS`: payload of last completed write frame
- `o_rx_dv` out 1: one-cycle pulse; the `o_cmd`, `o_addr` and `o_payload` outputs were updated this cycle
- `o_rd_req` out 1: one-cycle read request
- `o_rd_addr` out `ADDR_BITS`: address for `o_rd_req`
- `i_rd_data` in `PAYLOAD_BITS`: read data; must be valid exactly one cycle after `o_rd_req`
- `o_frame_err` out 1: one-cycle pulse; `cs_n` rose before the frame completed

## Operation
- Input path: `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` flops.
- Edge detect:
  - The previous synchronised `sclk` is registered.
  - Leading/trailing edges are derived with `CPOL` applied.
  - The sample edge is leading if `CPHA`=0, else trailing. The shift edge is the other edge.
- FSM states: IDLE, CMD, ADDR, DATA, DONE, DRAIN.
  - IDLE → CMD on synchronised `cs_n` falling. The bit counter and RX shift register are cleared. The TX shift register is loaded with 0.
  - CMD: each sample edge shifts `mosi` into RX and increments the counter. At `CMD_BITS` the counter clears → ADDR.
  - ADDR: same, for `ADDR_BITS` bits. On completion → DATA.
    - If the command equals `CMD_READ`: `o_rd_req`=1 for one cycle, with `o_rd_addr` = the received address.
    - On the next cycle, `i_rd_data` is loaded into the TX shift register.
  - DATA: samples `PAYLOAD_BITS` bits → DONE.
  - DONE (one cycle):
    - For `CMD_WRITE`: `o_cmd`, `o_addr` and `o_payload` are updated and `o_rx_dv`=1.
    - For `CMD_READ` and any other code: no output update and no `o_rx_dv`.
    - → DRAIN.
  - DRAIN: ignores further SCLK edges until `cs_n` is high → IDLE.
- MISO:
  - Driven by TX shift MSB.
  - Each shift edge in DATA shifts TX left, with 0 fill.
  - MISO is 0 during CMD and ADDR, and during DATA of non-read frames.
- Abort:
  - Synchronised `cs_n` rising in CMD, ADDR or DATA → IDLE and `o_frame_err`=1 for one cycle.
  - Registered outputs keep their previous values; RX is discarded.
  - `cs_n` rising in DONE completes DONE first, with no error.
- A sample edge and a `cs_n` rise in the same cycle: the `cs_n` rise wins and the bit is discarded.

## Timing
- Reset values:
  - `o_cmd` = `CMD_NOP`, `o_addr` = `ADDR_NONE`, `o_payload` = `PAYLOAD_NONE`
  - `o_rx_dv`, `o_rd_req`, `o_frame_err`, `miso` and `miso_oe` = 0
  - FSM in IDLE
- Reset mid-frame returns everything to the reset values immediately. The next frame starts only after a fresh `cs_n` fall.
- Edge-to-action latency: `SYNC_STAGES`+1 `sysclk` cycles from the pin edge.
- `o_rx_dv` asserts `SYNC_STAGES`+2 cycles after the last sample edge.
- Read turnaround: `i_rd_data` is consumed 1 cycle after `o_rd_req`. The first payload bit is on `miso` before the next shift edge.
- Requires `sysclk` ≥ 8 × `sclk` frequency (125 MHz vs ≤ 15.6 MHz).
- For `CPHA`=0, `cs_n` must be low ≥ `SYNC_STAGES`+2 `sysclk` cycles before the first SCLK edge.

## Structure
- `params.vh` gains `CMD_READ` (8'h02) and `CMD_WRITE` (8'h01), alongside the existing `CMD_NOP`, `ADDR_NONE`, `PAYLOAD_NONE` and `CS_ASSERT`.
- FSM state encodings are local parameters.
- One sub-module: `spi_sync_edge`, the synchroniser plus CPOL/CPHA-aware sample/shift edge detector, parametrised by `SYNC_STAGES`, `CPOL` and `CPHA`.

## Test plan
- Mode 0, frame 0x01/0x03/0x80 → `o_rx_dv` single pulse; `o_cmd`=0x01, `o_addr`=0x03, `o_payload`=0x80.
- Mode 3 (`CPOL`=1, `CPHA`=1), same frame → identical outputs.
- Mode 1, read 0x02/0x05, with the bench returning 0xA5 one cycle after `o_rd_req` → `o_rd_addr`=0x05; MISO bits 1,0,1,0,0,1,0,1 during DATA; no `o_rx_dv`.
- `cs_n` raised after 12 bits → `o_frame_err` pulse; outputs unchanged; the following valid write frame is accepted.
- 30 SCLK cycles in one `cs_n` window → one `o_rx_dv`; extra bits ignored.
- `rst_n` low during ADDR → all outputs at reset values; a fresh frame decodes correctly.

Source files
------------

// File: rtl/spi_frame_slave_pkg.sv
// Shared constants and FSM state type for the SPI frame slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_frame_slave_pkg;

    // Reset / idle values of the frame outputs
    localparam logic [7:0] CMD_NOP      = 8'h00;
    localparam logic [7:0] ADDR_NONE    = 8'h00;
    localparam logic [7:0] PAYLOAD_NONE = 8'h00;

    // Chip select level meaning "selected"
    localparam logic       CS_ASSERT    = 1'b0;

    // Command codes
    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;

    // Frame FSM states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

endpackage

// File: rtl/spi_frame_slave_if.sv
// SPI pin bundle between an external master and the frame slave.
// Latency: n/a (wires only).
// Backpressure: none; SPI has no flow control, the master owns the clock.
// Ports: sclk, cs_n, mosi driven by the master; miso, miso_oe driven by the slave.
interface spi_frame_slave_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_frame_slave_sync.sv
// Synchronises sclk/cs_n/mosi into sysclk and derives mode-aware sample/shift and cs edges.
// Latency: SYNC_STAGES flops to the synced level, edge strobes valid in the following cycle.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
// Ports: sysclk, rst_n, raw sclk/cs_n/mosi in; cs_n_sync, mosi_sync, sample_edge,
//        shift_edge, cs_fall, cs_rise out.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic cs_n_sync,
    output logic mosi_sync,
    output logic sample_edge,
    output logic shift_edge,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sclk_prev;
    logic                   cs_prev;
    // Edges are suppressed until the chains and the prev flops hold genuine pin
    // samples; otherwise a cs_n held low through reset would look like a fresh fall.
    logic [SYNC_STAGES:0]   live_sr;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr   <= {SYNC_STAGES{CPOL}};
            cs_sr     <= '1;
            mosi_sr   <= '0;
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
            live_sr   <= '0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
            cs_prev   <= cs_sr[SYNC_STAGES-1];
            live_sr   <= {live_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic live;
    logic sclk_now_n;   // sclk with CPOL folded out: 1 = away from idle
    logic sclk_prev_n;
    logic leading;
    logic trailing;

    assign live        = live_sr[SYNC_STAGES];
    assign cs_n_sync   = cs_sr[SYNC_STAGES-1];
    assign mosi_sync   = mosi_sr[SYNC_STAGES-1];
    assign sclk_now_n  = sclk_sr[SYNC_STAGES-1] ^ CPOL;
    assign sclk_prev_n = sclk_prev ^ CPOL;
    assign leading     = live &  sclk_now_n & ~sclk_prev_n;
    assign trailing    = live & ~sclk_now_n &  sclk_prev_n;
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading  : trailing;
    assign cs_fall     = live &  cs_prev & ~cs_n_sync;
    assign cs_rise     = live & ~cs_prev &  cs_n_sync;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave decoding cmd/addr/payload frames; write frames pulse out, read frames fetch and shift data.
// Latency: pin edge to action SYNC_STAGES+1 sysclk; o_rx_dv SYNC_STAGES+2 after last sample edge.
// Backpressure: none; o_rx_dv/o_rd_req are one-cycle pulses, i_rd_data is taken 1 cycle after o_rd_req.
// Ports: sysclk, rst_n; spi (slave modport: sclk, cs_n, mosi, miso, miso_oe);
//        o_cmd/o_addr/o_payload/o_rx_dv write result; o_rd_req/o_rd_addr/i_rd_data read port;
//        o_frame_err abort pulse.
module spi_frame_slave
    import spi_frame_slave_pkg::*;
#(
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8,
    parameter bit CPOL         = 1'b0,
    parameter bit CPHA         = 1'b0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    spi_frame_slave_if.slave        spi,
    output logic [CMD_BITS-1:0]     o_cmd,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_payload,
    output logic                    o_rx_dv,
    output logic                    o_rd_req,
    output logic [ADDR_BITS-1:0]    o_rd_addr,
    input  logic [PAYLOAD_BITS-1:0] i_rd_data,
    output logic                    o_frame_err
);

    localparam int MAXB_CA = (CMD_BITS > ADDR_BITS) ? CMD_BITS : ADDR_BITS;
    localparam int MAXB    = (MAXB_CA > PAYLOAD_BITS) ? MAXB_CA : PAYLOAD_BITS;
    localparam int CNT_W   = $clog2(MAXB + 1);

    localparam logic [CMD_BITS-1:0]     CMD_READ_W  = CMD_BITS'(CMD_READ);
    localparam logic [CMD_BITS-1:0]     CMD_WRITE_W = CMD_BITS'(CMD_WRITE);
    localparam logic [CNT_W-1:0]        CMD_LAST    = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0]        ADDR_LAST   = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0]        DATA_LAST   = CNT_W'(PAYLOAD_BITS);

    logic cs_n_sync, mosi_sync, sample_edge, shift_edge, cs_fall, cs_rise;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .CPOL        (CPOL),
        .CPHA        (CPHA)
    ) u_sync (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .sclk        (spi.sclk),
        .cs_n        (spi.cs_n),
        .mosi        (spi.mosi),
        .cs_n_sync   (cs_n_sync),
        .mosi_sync   (mosi_sync),
        .sample_edge (sample_edge),
        .shift_edge  (shift_edge),
        .cs_fall     (cs_fall),
        .cs_rise     (cs_rise)
    );

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [MAXB-2:0]         rx_q, rx_d;
    logic [MAXB-1:0]         rx_shift;
    logic [PAYLOAD_BITS-1:0] tx_q, tx_d;
    logic [CMD_BITS-1:0]     cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0] pay_q, pay_d;
    logic                    rd_pend_q;
    logic [CMD_BITS-1:0]     o_cmd_d;
    logic [ADDR_BITS-1:0]    o_addr_d, o_rd_addr_d;
    logic [PAYLOAD_BITS-1:0] o_payload_d;
    logic                    rx_dv_d, rd_req_d, frame_err_d;

    assign cnt_inc  = cnt_q + 1'b1;
    assign rx_shift = {rx_q, mosi_sync};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cmd_q       <= CMD_BITS'(CMD_NOP);
            addr_q      <= ADDR_BITS'(ADDR_NONE);
            pay_q       <= PAYLOAD_BITS'(PAYLOAD_NONE);
            rd_pend_q   <= 1'b0;
            o_cmd       <= CMD_BITS'(CMD_NOP);
            o_addr      <= ADDR_BITS'(ADDR_NONE);
            o_payload   <= PAYLOAD_BITS'(PAYLOAD_NONE);
            o_rx_dv     <= 1'b0;
            o_rd_req    <= 1'b0;
            o_rd_addr   <= ADDR_BITS'(ADDR_NONE);
            o_frame_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            pay_q       <= pay_d;
            rd_pend_q   <= o_rd_req;
            o_cmd       <= o_cmd_d;
            o_addr      <= o_addr_d;
            o_payload   <= o_payload_d;
            o_rx_dv     <= rx_dv_d;
            o_rd_req    <= rd_req_d;
            o_rd_addr   <= o_rd_addr_d;
            o_frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        pay_d       = pay_q;
        o_cmd_d     = o_cmd;
        o_addr_d    = o_addr;
        o_payload_d = o_payload;
        o_rd_addr_d = o_rd_addr;
        rx_dv_d     = 1'b0;
        rd_req_d    = 1'b0;
        frame_err_d = 1'b0;

        // Read data arrives one cycle after the request; it lands long before
        // the next SCLK edge, so it never collides with a shift.
        if (rd_pend_q) begin
            tx_d = i_rd_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                // A cs_n rise beats a same-cycle sample edge: the bit is dropped.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else if (sample_edge) begin
                    rx_d  = rx_shift[MAXB-2:0];
                    cnt_d = cnt_inc;
                    if (state_q == ST_CMD && cnt_inc == CMD_LAST) begin
                        cnt_d   = '0;
                        cmd_d   = rx_shift[CMD_BITS-1:0];
                        state_d = ST_ADDR;
                    end else if (state_q == ST_ADDR && cnt_inc == ADDR_LAST) begin
                        cnt_d   = '0;
                        addr_d  = rx_shift[ADDR_BITS-1:0];
                        state_d = ST_DATA;
                        if (cmd_q == CMD_READ_W) begin
                            rd_req_d    = 1'b1;
                            o_rd_addr_d = rx_shift[ADDR_BITS-1:0];
                        end
                    end else if (state_q == ST_DATA && cnt_inc == DATA_LAST) begin
                        cnt_d   = '0;
                        pay_d   = rx_shift[PAYLOAD_BITS-1:0];
                        state_d = ST_DONE;
                    end
                end else if (shift_edge && state_q == ST_DATA && cnt_q != '0) begin
                    // The first shift edge of DATA presents the MSB already
                    // loaded; only later shift edges advance to the next bit.
                    tx_d = {tx_q[PAYLOAD_BITS-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (cmd_q == CMD_WRITE_W) begin
                    o_cmd_d     = cmd_q;
                    o_addr_d    = addr_q;
                    o_payload_d = pay_q;
                    rx_dv_d     = 1'b1;
                end
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cs_n_sync != CS_ASSERT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign spi.miso    = tx_q[PAYLOAD_BITS-1];
    assign spi.miso_oe = (cs_n_sync == CS_ASSERT);

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench: three slaves (mode 0, mode 3, mode 1) on one sysclk, driven one at a time
// by a bit-banged master; write results and read addresses go through scoreboards.
module tb_spi_frame_slave;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       drv_sclk = 1'b0, drv_cs_n = 1'b1, drv_mosi = 1'b0;
    int         sel = 0;
    logic [7:0] rd_data = 8'h5A;
    logic [7:0] rd_resp = 8'h00;

    logic [7:0] cmd_o [3];
    logic [7:0] addr_o [3];
    logic [7:0] pay_o [3];
    logic [7:0] rd_addr_o [3];
    logic       rx_dv [3];
    logic       rd_req [3];
    logic       ferr [3];

    int checks = 0, errors = 0;
    int rx_cnt [3] = '{0, 0, 0};
    int err_cnt [3] = '{0, 0, 0};
    int rd_cnt = 0, bad_rd = 0;
    logic [31:0] miso_word;

    typedef struct {
        int         dut;
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] pay;
    } exp_t;
    exp_t       exp_q[$];
    logic [7:0] rd_q[$];

    always #4 sysclk = ~sysclk;

    spi_frame_slave_if bus0 ();
    spi_frame_slave_if bus1 ();
    spi_frame_slave_if bus2 ();

    assign bus0.sclk = (sel == 0) ? drv_sclk : 1'b0;
    assign bus0.cs_n = (sel == 0) ? drv_cs_n : 1'b1;
    assign bus0.mosi = (sel == 0) ? drv_mosi : 1'b0;
    assign bus1.sclk = (sel == 1) ? drv_sclk : 1'b1;
    assign bus1.cs_n = (sel == 1) ? drv_cs_n : 1'b1;
    assign bus1.mosi = (sel == 1) ? drv_mosi : 1'b0;
    assign bus2.sclk = (sel == 2) ? drv_sclk : 1'b0;
    assign bus2.cs_n = (sel == 2) ? drv_cs_n : 1'b1;
    assign bus2.mosi = (sel == 2) ? drv_mosi : 1'b0;

    logic miso_sel, oe_sel;
    assign miso_sel = (sel == 0) ? bus0.miso : (sel == 1) ? bus1.miso : bus2.miso;
    assign oe_sel   = (sel == 0) ? bus0.miso_oe : (sel == 1) ? bus1.miso_oe : bus2.miso_oe;

    spi_frame_slave #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .sysclk(sysclk), .rst_n(rst_n), .spi(bus0),
        .o_cmd(cmd_o[0]), .o_addr(addr_o[0]), .o_payload(pay_o[0]), .o_rx_dv(rx_dv[0]),
        .o_rd_req(rd_req[0]), .o_rd_addr(rd_addr_o[0]), .i_rd_data(rd_data), .o_frame_err(ferr[0]));

    spi_frame_slave #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .sysclk(sysclk), .rst_n(rst_n), .spi(bus1),
        .o_cmd(cmd_o[1]), .o_addr(addr_o[1]), .o_payload(pay_o[1]), .o_rx_dv(rx_dv[1]),
        .o_rd_req(rd_req[1]), .o_rd_addr(rd_addr_o[1]), .i_rd_data(rd_data), .o_frame_err(ferr[1]));

    spi_frame_slave #(.CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .sysclk(sysclk), .rst_n(rst_n), .spi(bus2),
        .o_cmd(cmd_o[2]), .o_addr(addr_o[2]), .o_payload(pay_o[2]), .o_rx_dv(rx_dv[2]),
        .o_rd_req(rd_req[2]), .o_rd_addr(rd_addr_o[2]), .i_rd_data(rd_data), .o_frame_err(ferr[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Half an SCLK period: 8 sysclk cycles, pins change 1 ns after the edge.
    task automatic half();
        repeat (8) @(posedge sysclk);
        #1;
    endtask

    function automatic logic cpol_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic cpha_of(input int k);
        return (k != 0);
    endfunction

    // Master: clocks nbits of word (MSB first) into slave k, capturing MISO at each
    // master sample point into miso_word.
    task automatic xfer(input int k, input logic [31:0] word, input int nbits, input bit keep_cs);
        drv_sclk  = cpol_of(k);
        sel       = k;
        miso_word = '0;
        drv_cs_n  = 1'b0;
        drv_mosi  = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_of(k)) begin
                drv_mosi = word[nbits-1-i];
                half();
                miso_word = {miso_word[30:0], miso_sel};
                if (i == 0) chk("miso_oe_active", 32'(oe_sel), 32'h1);
                drv_sclk = ~cpol_of(k);
                half();
                drv_sclk = cpol_of(k);
            end else begin
                drv_sclk = ~cpol_of(k);
                drv_mosi = word[nbits-1-i];
                half();
                miso_word = {miso_word[30:0], miso_sel};
                if (i == 0) chk("miso_oe_active", 32'(oe_sel), 32'h1);
                drv_sclk = cpol_of(k);
                half();
            end
        end
        half();
        if (!keep_cs) begin
            drv_cs_n = 1'b1;
            half();
            half();
        end
    endtask

    task automatic push_wr(input int k, input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        exp_t e;
        e.dut = k; e.cmd = c; e.addr = a; e.pay = p;
        exp_q.push_back(e);
    endtask

    // Output monitor: every o_rx_dv cycle pops one expected write.
    initial begin
        forever begin
            @(negedge sysclk);
            for (int k = 0; k < 3; k++) begin
                if (rx_dv[k] === 1'b1) begin
                    rx_cnt[k]++;
                    if (exp_q.size() == 0) begin
                        chk("rx_dv_unexpected", 32'(k), 32'hFFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rx_dut", 32'(k), 32'(e.dut));
                        chk("rx_cmd", 32'(cmd_o[k]), 32'(e.cmd));
                        chk("rx_addr", 32'(addr_o[k]), 32'(e.addr));
                        chk("rx_payload", 32'(pay_o[k]), 32'(e.pay));
                    end
                end
                if (ferr[k] === 1'b1) err_cnt[k]++;
                if (k != 2 && rd_req[k] === 1'b1) bad_rd++;
            end
        end
    end

    // Register-file model for the mode-1 slave: data valid exactly one cycle after o_rd_req.
    initial begin
        forever begin
            @(negedge sysclk);
            if (rd_req[2] === 1'b1) begin
                rd_cnt++;
                if (rd_q.size() == 0) chk("rd_req_unexpected", 32'(rd_addr_o[2]), 32'hFFFF);
                else chk("rd_addr", 32'(rd_addr_o[2]), 32'(rd_q.pop_front()));
                @(posedge sysclk);
                #1 rd_data = rd_resp;
                @(posedge sysclk);
                #1 rd_data = 8'h5A;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_cmd", 32'(cmd_o[0]), 32'h00);
        chk("rst_addr", 32'(addr_o[0]), 32'h00);
        chk("rst_payload", 32'(pay_o[0]), 32'h00);
        chk("rst_rx_dv", 32'(rx_dv[0]), 32'h0);
        chk("rst_rd_req", 32'(rd_req[0]), 32'h0);
        chk("rst_frame_err", 32'(ferr[0]), 32'h0);
        chk("rst_miso", 32'(bus0.miso), 32'h0);
        chk("rst_miso_oe", 32'(bus0.miso_oe), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(posedge sysclk);
        #1;
        chk("idle_miso_oe", 32'(bus0.miso_oe), 32'h0);

        // Mode 0 write
        push_wr(0, 8'h01, 8'h03, 8'h80);
        xfer(0, 32'h010380, 24, 1'b0);
        chk("m0_cmd_held", 32'(cmd_o[0]), 32'h01);
        chk("m0_payload_held", 32'(pay_o[0]), 32'h80);
        chk("m0_rx_dv_count", 32'(rx_cnt[0]), 32'd1);
        chk("m0_miso_quiet", miso_word[23:0], 32'h0);

        // Mode 3, same frame
        push_wr(1, 8'h01, 8'h03, 8'h80);
        xfer(1, 32'h010380, 24, 1'b0);
        chk("m3_rx_dv_count", 32'(rx_cnt[1]), 32'd1);

        // Mode 1 read of address 0x05, register file returns 0xA5
        rd_resp = 8'hA5;
        rd_q.push_back(8'h05);
        xfer(2, 32'h0205FF, 24, 1'b0);
        chk("rd_miso_data", 32'(miso_word[7:0]), 32'hA5);
        chk("rd_miso_quiet_hdr", 32'(miso_word[23:8]), 32'h0);
        chk("rd_req_count", 32'(rd_cnt), 32'd1);
        chk("rd_no_rx_dv", 32'(rx_cnt[2]), 32'd0);
        chk("rd_cmd_unchanged", 32'(cmd_o[2]), 32'h00);

        // Abort after 12 bits, then a good frame
        xfer(0, 32'h00000144, 12, 1'b0);
        chk("abort_err_count", 32'(err_cnt[0]), 32'd1);
        chk("abort_cmd_kept", 32'(cmd_o[0]), 32'h01);
        chk("abort_addr_kept", 32'(addr_o[0]), 32'h03);
        chk("abort_payload_kept", 32'(pay_o[0]), 32'h80);
        push_wr(0, 8'h01, 8'h7E, 8'hC3);
        xfer(0, 32'h017EC3, 24, 1'b0);
        chk("after_abort_rx_dv", 32'(rx_cnt[0]), 32'd2);

        // 30 clocks in one cs_n window: only the first 24 bits count
        push_wr(0, 8'h01, 8'h11, 8'h22);
        xfer(0, {2'b00, 24'h011122, 6'b101101}, 30, 1'b0);
        chk("long_rx_dv_count", 32'(rx_cnt[0]), 32'd3);
        chk("long_no_err", 32'(err_cnt[0]), 32'd1);

        // Reset during ADDR with cs_n held low
        xfer(0, 32'h00000199, 12, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_cmd", 32'(cmd_o[0]), 32'h00);
        chk("midrst_addr", 32'(addr_o[0]), 32'h00);
        chk("midrst_payload", 32'(pay_o[0]), 32'h00);
        chk("midrst_miso_oe", 32'(bus0.miso_oe), 32'h0);
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge sysclk);
        #1;
        // cs_n still low from before reset: these clocks must not start a frame
        xfer(0, 32'h0000000F, 4, 1'b0);
        chk("no_frame_without_fall_err", 32'(err_cnt[0]), 32'd1);
        chk("no_frame_without_fall_dv", 32'(rx_cnt[0]), 32'd3);
        push_wr(0, 8'h01, 8'h5A, 8'h0F);
        xfer(0, 32'h015A0F, 24, 1'b0);
        chk("post_rst_rx_dv", 32'(rx_cnt[0]), 32'd4);
        chk("post_rst_addr", 32'(addr_o[0]), 32'h5A);

        repeat (10) @(posedge sysclk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("no_stray_rd_req", 32'(bad_rd), 32'd0);
        chk("m3_no_err", 32'(err_cnt[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
